// File: rtl/mult32_accum_stage_pkg.sv
// Shared widths, frame-length limit and FSM state encoding for the multiply-accumulate stage.
package mult32_accum_stage_pkg;

   localparam int DEF_W         = 64;
   localparam int DEF_MAX_TERMS = 1024;
   localparam int DEF_CNT_W     = 11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/mult32_accum_stage_if.sv
// Product-in and result-out handshake bundle; slave is the accumulator stage, master drives it.
interface mult32_accum_stage_if #(
   parameter int W     = 64,
   parameter int CNT_W = 11
) ();

   logic [W-1:0]     prod_i;
   logic             prod_valid_i;
   logic             prod_last_i;
   logic             prod_ready_o;
   logic [W-1:0]     sum_o;
   logic             sum_valid_o;
   logic             sum_ready_i;
   logic [CNT_W-1:0] term_cnt_o;
   logic             ovf_o;
   logic             trunc_o;

   modport slave (
      input  prod_i, prod_valid_i, prod_last_i, sum_ready_i,
      output prod_ready_o, sum_o, sum_valid_o, term_cnt_o, ovf_o, trunc_o
   );

   modport master (
      output prod_i, prod_valid_i, prod_last_i, sum_ready_i,
      input  prod_ready_o, sum_o, sum_valid_o, term_cnt_o, ovf_o, trunc_o
   );

endinterface

// File: rtl/mult32_accum_stage_add64.sv
// Unsigned adder with explicit carry-out; the carry feeds the sticky overflow flag.
module mult32_accum_stage_add64 #(
   parameter int W = 64
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] sum_o,
   output logic         carry_o
);

   assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/mult32_accum_stage.sv
// Accumulates a frame of products into a sum and presents it on a valid/ready result port.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no frame open; next accepted product starts a frame
// ST_ACCUM | frame open; products added into the accumulator
// ST_HOLD  | frame closed; result held on the output until transferred
module mult32_accum_stage
   import mult32_accum_stage_pkg::*;
#(
   parameter int W         = DEF_W,
   parameter int MAX_TERMS = DEF_MAX_TERMS,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear_i,
   mult32_accum_stage_if.slave      io
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TERMS);

   state_t           state_q, state_d;
   logic [W-1:0]     acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             trunc_q, trunc_d;

   logic [W-1:0]     add_sum;
   logic             add_carry;
   logic [CNT_W-1:0] cnt_inc;
   logic             accept;
   logic             xfer;
   logic             start;

   mult32_accum_stage_add64 #(.W(W)) u_add (
      .a_i     (acc_q),
      .b_i     (io.prod_i),
      .sum_o   (add_sum),
      .carry_o (add_carry)
   );

   // HOLD is the only buffer, so a new product may enter only as the held result leaves.
   assign io.prod_ready_o = (state_q != ST_HOLD) || io.sum_ready_i;
   assign io.sum_valid_o  = (state_q == ST_HOLD);
   assign io.sum_o        = acc_q;
   assign io.term_cnt_o   = cnt_q;
   assign io.ovf_o        = ovf_q;
   assign io.trunc_o      = trunc_q;

   assign accept  = io.prod_valid_i && io.prod_ready_o;
   assign xfer    = io.sum_valid_o && io.sum_ready_i;
   assign cnt_inc = cnt_q + CNT_ONE;
   assign start   = accept && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && xfer));

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      trunc_d = trunc_q;
      if (clear_i) begin
         state_d = ST_IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
         trunc_d = 1'b0;
      end else if (start) begin
         acc_d   = io.prod_i;
         cnt_d   = CNT_ONE;
         ovf_d   = 1'b0;
         trunc_d = !io.prod_last_i && (CNT_ONE == CNT_MAX);
         state_d = (io.prod_last_i || (CNT_ONE == CNT_MAX)) ? ST_HOLD : ST_ACCUM;
      end else if ((state_q == ST_ACCUM) && accept) begin
         acc_d = add_sum;
         cnt_d = cnt_inc;
         ovf_d = ovf_q | add_carry;
         if (io.prod_last_i) begin
            state_d = ST_HOLD;
         end else if (cnt_inc == CNT_MAX) begin
            state_d = ST_HOLD;
            trunc_d = 1'b1;
         end
      end else if ((state_q == ST_HOLD) && xfer) begin
         state_d = ST_IDLE;
      end else if ((state_q != ST_IDLE) && (state_q != ST_ACCUM) && (state_q != ST_HOLD)) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         trunc_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         trunc_q <= trunc_d;
      end
   end

endmodule

// File: tb/tb_mult32_accum_stage.sv
// Directed bench for mult32_accum_stage built with a 4-term frame limit so forced close is reachable.
module tb_mult32_accum_stage;

   localparam int W         = 64;
   localparam int MAX_TERMS = 4;
   localparam int CNT_W     = 3;

   logic clk;
   logic rst;
   logic clear_i;
   int   total;
   int   bad;

   mult32_accum_stage_if #(.W(W), .CNT_W(CNT_W)) io ();

   mult32_accum_stage #(.W(W), .MAX_TERMS(MAX_TERMS), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .clear_i (clear_i),
      .io      (io.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [W-1:0] p, input logic l);
      io.prod_valid_i = v;
      io.prod_i       = p;
      io.prod_last_i  = l;
   endtask

   task automatic test_reset();
      total++; if (io.sum_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", io.sum_valid_o); end
      total++; if (io.prod_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b exp=1", io.prod_ready_o); end
      total++; if (io.sum_o !== 64'd0) begin bad++; $display("FAIL rst_sum got=%0h exp=0", io.sum_o); end
      total++; if (io.term_cnt_o !== 3'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", io.term_cnt_o); end
      total++; if ({io.ovf_o, io.trunc_o} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b exp=00", {io.ovf_o, io.trunc_o}); end
   endtask

   task automatic test_frame3();
      io.sum_ready_i = 1'b1;
      drive(1'b1, 64'd5, 1'b0); cyc();
      drive(1'b1, 64'd7, 1'b0); cyc();
      total++; if (io.sum_valid_o !== 1'b0) begin bad++; $display("FAIL f3_early_valid got=%0b exp=0", io.sum_valid_o); end
      drive(1'b1, 64'd9, 1'b1); cyc();
      drive(1'b0, 64'd0, 1'b0);
      total++; if (io.sum_valid_o !== 1'b1) begin bad++; $display("FAIL f3_valid got=%0b exp=1", io.sum_valid_o); end
      total++; if (io.sum_o !== 64'd21) begin bad++; $display("FAIL f3_sum got=%0d exp=21", io.sum_o); end
      total++; if (io.term_cnt_o !== 3'd3) begin bad++; $display("FAIL f3_cnt got=%0d exp=3", io.term_cnt_o); end
      total++; if (io.ovf_o !== 1'b0) begin bad++; $display("FAIL f3_ovf got=%0b exp=0", io.ovf_o); end
      cyc();
      total++; if (io.sum_valid_o !== 1'b0) begin bad++; $display("FAIL f3_xfer got=%0b exp=0", io.sum_valid_o); end
   endtask

   task automatic test_overflow();
      io.sum_ready_i = 1'b1;
      drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0); cyc();
      drive(1'b1, 64'd2, 1'b1); cyc();
      drive(1'b0, 64'd0, 1'b0);
      total++; if (io.sum_o !== 64'd1) begin bad++; $display("FAIL ovf_sum got=%0h exp=1", io.sum_o); end
      total++; if (io.ovf_o !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", io.ovf_o); end
      total++; if (io.term_cnt_o !== 3'd2) begin bad++; $display("FAIL ovf_cnt got=%0d exp=2", io.term_cnt_o); end
      cyc();
   endtask

   task automatic test_back_to_back();
      io.sum_ready_i = 1'b0;
      drive(1'b1, 64'd6, 1'b1); cyc();
      drive(1'b1, 64'd4, 1'b1);
      for (int i = 0; i < 5; i++) begin
         total++; if (io.prod_ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%0b exp=0", i, io.prod_ready_o); end
         total++; if ({io.sum_valid_o, io.sum_o, io.term_cnt_o, io.ovf_o} !== {1'b1, 64'd6, 3'd1, 1'b0}) begin
            bad++; $display("FAIL bp_hold[%0d] got v=%0b s=%0d c=%0d o=%0b exp v=1 s=6 c=1 o=0",
                            i, io.sum_valid_o, io.sum_o, io.term_cnt_o, io.ovf_o);
         end
         cyc();
      end
      io.sum_ready_i = 1'b1;
      #1;
      total++; if (io.prod_ready_o !== 1'b1) begin bad++; $display("FAIL bp_ready_rel got=%0b exp=1", io.prod_ready_o); end
      cyc();
      drive(1'b0, 64'd0, 1'b0);
      total++; if ({io.sum_valid_o, io.sum_o, io.term_cnt_o} !== {1'b1, 64'd4, 3'd1}) begin
         bad++; $display("FAIL b2b_next got v=%0b s=%0d c=%0d exp v=1 s=4 c=1", io.sum_valid_o, io.sum_o, io.term_cnt_o);
      end
      cyc();
      total++; if (io.sum_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%0b exp=0", io.sum_valid_o); end
   endtask

   task automatic test_force_close();
      io.sum_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total++; if (io.sum_valid_o !== 1'b0) begin bad++; $display("FAIL fc_early[%0d] got=%0b exp=0", i, io.sum_valid_o); end
         drive(1'b1, 64'd1, 1'b0); cyc();
      end
      total++; if (io.sum_valid_o !== 1'b1) begin bad++; $display("FAIL fc_valid got=%0b exp=1", io.sum_valid_o); end
      total++; if (io.sum_o !== 64'd4) begin bad++; $display("FAIL fc_sum got=%0d exp=4", io.sum_o); end
      total++; if (io.term_cnt_o !== 3'd4) begin bad++; $display("FAIL fc_cnt got=%0d exp=4", io.term_cnt_o); end
      total++; if (io.trunc_o !== 1'b1) begin bad++; $display("FAIL fc_trunc got=%0b exp=1", io.trunc_o); end
      total++; if (io.prod_ready_o !== 1'b0) begin bad++; $display("FAIL fc_ready got=%0b exp=0", io.prod_ready_o); end
      io.sum_ready_i = 1'b1;
      drive(1'b1, 64'd2, 1'b1); cyc();
      drive(1'b0, 64'd0, 1'b0);
      total++; if ({io.sum_valid_o, io.sum_o, io.term_cnt_o, io.trunc_o} !== {1'b1, 64'd2, 3'd1, 1'b0}) begin
         bad++; $display("FAIL fc_next got v=%0b s=%0d c=%0d t=%0b exp v=1 s=2 c=1 t=0",
                         io.sum_valid_o, io.sum_o, io.term_cnt_o, io.trunc_o);
      end
      cyc();
   endtask

   task automatic test_clear();
      io.sum_ready_i = 1'b1;
      drive(1'b1, 64'd10, 1'b0); cyc();
      drive(1'b1, 64'd20, 1'b0); cyc();
      drive(1'b0, 64'd0, 1'b0);
      clear_i = 1'b1;
      #1;
      total++; if (io.prod_ready_o !== 1'b1) begin bad++; $display("FAIL clr_ready got=%0b exp=1", io.prod_ready_o); end
      cyc();
      clear_i = 1'b0;
      total++; if ({io.sum_valid_o, io.sum_o, io.term_cnt_o} !== {1'b0, 64'd0, 3'd0}) begin
         bad++; $display("FAIL clr_accum got v=%0b s=%0d c=%0d exp v=0 s=0 c=0", io.sum_valid_o, io.sum_o, io.term_cnt_o);
      end
      io.sum_ready_i = 1'b0;
      drive(1'b1, 64'd3, 1'b1); cyc();
      drive(1'b0, 64'd0, 1'b0);
      total++; if ({io.sum_valid_o, io.sum_o, io.term_cnt_o} !== {1'b1, 64'd3, 3'd1}) begin
         bad++; $display("FAIL clr_after got v=%0b s=%0d c=%0d exp v=1 s=3 c=1", io.sum_valid_o, io.sum_o, io.term_cnt_o);
      end
      clear_i = 1'b1;
      io.sum_ready_i = 1'b1;
      drive(1'b1, 64'd50, 1'b1); cyc();
      clear_i = 1'b0;
      drive(1'b0, 64'd0, 1'b0);
      total++; if ({io.sum_valid_o, io.sum_o, io.term_cnt_o} !== {1'b0, 64'd0, 3'd0}) begin
         bad++; $display("FAIL clr_hold got v=%0b s=%0d c=%0d exp v=0 s=0 c=0", io.sum_valid_o, io.sum_o, io.term_cnt_o);
      end
   endtask

   task automatic test_async_reset();
      io.sum_ready_i = 1'b1;
      drive(1'b1, 64'd5, 1'b0); cyc();
      drive(1'b0, 64'd0, 1'b0);
      total++; if ({io.sum_o, io.term_cnt_o} !== {64'd5, 3'd1}) begin
         bad++; $display("FAIL ar_pre got s=%0d c=%0d exp s=5 c=1", io.sum_o, io.term_cnt_o);
      end
      #2 rst = 1'b1;
      #1;
      total++; if ({io.sum_valid_o, io.sum_o, io.term_cnt_o, io.ovf_o, io.trunc_o} !== {1'b0, 64'd0, 3'd0, 1'b0, 1'b0}) begin
         bad++; $display("FAIL ar_now got v=%0b s=%0d c=%0d exp v=0 s=0 c=0", io.sum_valid_o, io.sum_o, io.term_cnt_o);
      end
      #1 rst = 1'b0;
      drive(1'b1, 64'd8, 1'b1); cyc();
      drive(1'b0, 64'd0, 1'b0);
      total++; if ({io.sum_valid_o, io.sum_o, io.term_cnt_o} !== {1'b1, 64'd8, 3'd1}) begin
         bad++; $display("FAIL ar_after got v=%0b s=%0d c=%0d exp v=1 s=8 c=1", io.sum_valid_o, io.sum_o, io.term_cnt_o);
      end
      cyc();
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      rst     = 1'b1;
      clear_i = 1'b0;
      io.sum_ready_i = 1'b0;
      drive(1'b0, 64'd0, 1'b0);
      repeat (3) cyc();
      test_reset();
      rst = 1'b0;
      cyc();
      test_frame3();
      test_overflow();
      test_back_to_back();
      test_force_close();
      test_clear();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
